// File: rtl/ex_div.sv
// Multi-cycle integer divider for the EX stage: DIV/DIVU/REM/REMU via 32-step
// restoring division on magnitudes, with single-cycle handling of div-by-zero and signed overflow.
module ex_div #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    div_op,
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  input  logic [4:0]    waddr,
  input  logic          flush,
  output logic          stall_req,
  output logic          done,
  output logic [DW-1:0] result,
  output logic [4:0]    res_waddr
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  state_e        state_q;
  logic [4:0]    cnt_q;
  logic [DW-1:0] dvd_q, dvs_q, rem_q;
  logic [1:0]    op_q;
  logic          qneg_q, rneg_q;
  logic [4:0]    waddr_q;
  logic          done_q;
  logic [DW-1:0] result_q;
  logic [4:0]    res_waddr_q;

  // Operand decode in IDLE: div_op[0]=1 means unsigned, div_op[1]=1 means remainder.
  logic          sgn, a_neg, b_neg, div0, ovf;
  logic [DW-1:0] a_mag, b_mag, spec_d;

  assign sgn    = ~div_op[0];
  assign a_neg  = sgn & op1[DW-1];
  assign b_neg  = sgn & op2[DW-1];
  assign a_mag  = a_neg ? -op1 : op1;
  assign b_mag  = b_neg ? -op2 : op2;
  assign div0   = (op2 == '0);
  assign ovf    = sgn & (op1 == SMIN) & (op2 == '1);
  assign spec_d = div0 ? (div_op[1] ? op1 : '1) : (div_op[1] ? '0 : SMIN);

  // One restoring step: quotient bits shift into dvd_q as the dividend shifts out.
  logic [DW:0]   trial_d, diff_d;
  logic          ge_d;
  logic [DW-1:0] rem_d, quo_d, res_d;

  assign trial_d = {rem_q, dvd_q[DW-1]};
  assign diff_d  = trial_d - {1'b0, dvs_q};
  assign ge_d    = ~diff_d[DW];
  assign rem_d   = ge_d ? diff_d[DW-1:0] : trial_d[DW-1:0];
  assign quo_d   = {dvd_q[DW-2:0], ge_d};
  assign res_d   = op_q[1] ? (rneg_q ? -rem_d : rem_d)
                           : (qneg_q ? -quo_d : quo_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      op_q        <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      waddr_q     <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      res_waddr_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q   <= a_mag;
            dvs_q   <= b_mag;
            rem_q   <= '0;
            op_q    <= div_op;
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            waddr_q <= waddr;
            cnt_q   <= '0;
            if (div0 || ovf) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              result_q    <= spec_d;
              res_waddr_q <= waddr;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          dvd_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            result_q    <= res_d;
            res_waddr_q <= waddr_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by rst so a start asserted during reset cannot stall the pipeline.
  assign stall_req = rst & (((state_q == IDLE) & start & ~flush) | (state_q == CALC));
  assign done      = done_q;
  assign result    = result_q;
  assign res_waddr = res_waddr_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: arithmetic reference model with a per-cycle compare,
// plus directed vectors with hand-computed results, latencies and reset/flush behaviour.
module tb_ex_div;

  logic        clk, rst, start, flush;
  logic [1:0]  div_op;
  logic [31:0] op1, op2;
  logic [4:0]  waddr;
  logic        stall_req, done;
  logic [31:0] result;
  logic [4:0]  res_waddr;

  int checks = 0;
  int fails  = 0;
  int stall_cnt;

  ex_div #(.DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .div_op(div_op), .op1(op1), .op2(op2),
    .waddr(waddr), .flush(flush), .stall_req(stall_req), .done(done),
    .result(result), .res_waddr(res_waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result: plain arithmetic, SV division truncates toward zero.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
    if (!op[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'd0 : 32'h80000000;
      return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return op[1] ? a % b : a / b;
  endfunction

  // Timeline model: an accepted request completes 32 edges later, special cases at once.
  int          cd;
  logic        exp_done;
  logic [31:0] exp_res, pend_res;
  logic [4:0]  exp_wa, pend_wa;
  logic        exp_stall;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd = -1; exp_done = 1'b0; exp_res = '0; exp_wa = '0;
    end else if (flush) begin
      cd = -1; exp_done = 1'b0;
    end else if (exp_done) begin
      exp_done = 1'b0;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        exp_done = 1'b1; exp_res = pend_res; exp_wa = pend_wa; cd = -1;
      end
    end else if (start) begin
      pend_res = ref_div(div_op, op1, op2);
      pend_wa  = waddr;
      if (op2 == 32'd0 || (!div_op[0] && op1 == 32'h80000000 && op2 == 32'hFFFFFFFF)) begin
        exp_done = 1'b1; exp_res = pend_res; exp_wa = pend_wa;
      end else begin
        cd = 32;
      end
    end
  end

  always_comb exp_stall = rst && (cd > 0 || (cd < 0 && !exp_done && start && !flush));

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_stall", {31'd0, stall_req}, {31'd0, exp_stall});
      chk("cyc_done", {31'd0, done}, {31'd0, exp_done});
      chk("cyc_result", result, exp_res);
      chk("cyc_waddr", {27'd0, res_waddr}, {27'd0, exp_wa});
    end
  end

  // Drive a request so it is sampled at the next edge; returns 2ns after that edge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    @(posedge clk); #2;
    start = 1'b1; div_op = op; op1 = a; op2 = b; waddr = wa;
    #1 stall_cnt = stall_req ? 1 : 0;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Latency counted from the start cycle to the done cycle; optional start injection mid-CALC.
  task automatic wait_done(input int inj_at, output int lat, output logic [31:0] res, output logic [4:0] wa);
    int j;
    for (j = 0; j < 100; j++) begin
      if (done) break;
      if (stall_req) stall_cnt++;
      if (j == inj_at) begin
        start = 1'b1; div_op = 2'b01; op1 = 32'd50; op2 = 32'd5; waddr = 5'd7;
      end else if (j == inj_at + 1) begin
        start = 1'b0; op1 = 32'd100; op2 = 32'd7;
      end
      @(posedge clk); #2;
    end
    start = 1'b0;
    if (j == 100) chk("done_timeout", 32'd0, 32'd1);
    else chk("stall_low_in_done", {31'd0, stall_req}, 32'd0);
    lat = j + 1; res = result; wa = res_waddr;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic [31:0] exp_r, input int exp_lat);
    int lat; logic [31:0] r; logic [4:0] w;
    launch(op, a, b, wa);
    wait_done(-10, lat, r, w);
    chk({name, "_result"}, r, exp_r);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_waddr"}, {27'd0, w}, {27'd0, wa});
  endtask

  initial begin
    int lat; logic [31:0] r, prev; logic [4:0] w;
    rst = 1'b0; start = 1'b0; flush = 1'b0; div_op = '0; op1 = '0; op2 = '0; waddr = '0;
    #3;
    start = 1'b1; op1 = 32'd9; op2 = 32'd3;
    #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_waddr", {27'd0, res_waddr}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    start = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    chk_en = 1'b1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 33);
    chk("divu_stall_cycles", stall_cnt, 33);
    run_op("rem_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFF, 33);
    run_op("div_m7_2", 2'b00, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 33);
    run_op("divu_by0", 2'b01, 32'd5, 32'd0, 5'd8, 32'hFFFFFFFF, 1);
    chk("div0_stall_cycles", stall_cnt, 1);
    run_op("remu_by0", 2'b11, 32'd5, 32'd0, 5'd9, 32'd5, 1);
    run_op("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1);
    run_op("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0, 1);
    run_op("div_100_m7", 2'b00, 32'd100, 32'hFFFFFFF9, 5'd12, 32'hFFFFFFF2, 33);
    run_op("rem_m100_7", 2'b10, 32'hFFFFFF9C, 32'd7, 5'd13, 32'hFFFFFFFE, 33);
    run_op("div_m7_m2", 2'b00, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd14, 32'd3, 33);
    run_op("remu_big", 2'b11, 32'hFFFFFFFF, 32'd10, 5'd15, 32'd5, 33);
    run_op("divu_small_big", 2'b01, 32'd3, 32'hFFFFFFF0, 5'd16, 32'd0, 33);

    // Flush in the 10th CALC cycle.
    prev = result;
    launch(2'b01, 32'd1000, 32'd3, 5'd20);
    repeat (9) begin @(posedge clk); #2; end
    chk("flush_stall_before", {31'd0, stall_req}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #2 flush = 1'b0;
    chk("flush_idle_stall", {31'd0, stall_req}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    lat = 0;
    repeat (40) begin @(posedge clk); #2 if (done) lat++; end
    chk("flush_no_done", lat, 32'd0);
    chk("flush_result_kept", result, prev);

    // Start injected mid-CALC is ignored.
    launch(2'b01, 32'd100, 32'd7, 5'd4);
    wait_done(5, lat, r, w);
    chk("inject_result", r, 32'd14);
    chk("inject_waddr", {27'd0, w}, 32'd4);
    chk("inject_latency", lat, 33);

    // Reset mid-CALC clears outputs immediately and kills the operation.
    launch(2'b00, 32'hFFFFFF9C, 32'd7, 5'd21);
    repeat (10) begin @(posedge clk); #2; end
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_waddr", {27'd0, res_waddr}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_req}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    lat = 0;
    repeat (40) begin @(posedge clk); #2 if (done) lat++; end
    chk("mid_rst_no_done", lat, 32'd0);
    run_op("post_rst_remu", 2'b11, 32'd100, 32'd7, 5'd22, 32'd2, 33);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
